// File: rtl/log_calc_if.sv
// Handshake and operand/result bundle for the iterative logarithm unit.
interface log_calc_if #(
  parameter int depth = 3
);
  logic               start_i;
  logic [depth-1:0]   base_i;
  logic [2*depth-1:0] value_i;
  logic [depth-1:0]   result_o;
  logic               exact_o;
  logic               err_o;
  logic               finish_o;

  modport master (
    output start_i, base_i, value_i,
    input  result_o, exact_o, err_o, finish_o
  );

  modport slave (
    input  start_i, base_i, value_i,
    output result_o, exact_o, err_o, finish_o
  );
endinterface

// File: rtl/log_calc.sv
// Iterative floor(log_base(value)) with exact-power flag, one multiply per cycle.
module log_calc #(
  parameter int depth = 3
) (
  input  logic         clk,
  input  logic         rst,
  log_calc_if.slave    bus_io
);

  localparam int pw = 3 * depth;
  localparam logic [depth-1:0] one_c = depth'(1);
  localparam logic [depth-1:0] two_c = depth'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [depth-1:0]   base_q, base_d;
  logic [2*depth-1:0] value_q, value_d;
  logic [pw-1:0]      power_q, power_d;
  logic [depth-1:0]   count_q, count_d;
  logic [depth-1:0]   result_q, result_d;
  logic               exact_q, exact_d;
  logic               err_q, err_d;
  logic               finish_q, finish_d;

  logic [pw+depth-1:0] product;
  logic                step_ok;
  logic                bad_operands;

  // Product is kept one base-width wider than power so the compare never wraps.
  assign product      = {{depth{1'b0}}, power_q} * {{pw{1'b0}}, base_q};
  assign step_ok      = product <= {{(pw+depth-2*depth){1'b0}}, value_q};
  assign bad_operands = (base_q < two_c) || (value_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      value_q  <= '0;
      power_q  <= {{(pw-1){1'b0}}, 1'b1};
      count_q  <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      value_q  <= value_d;
      power_q  <= power_d;
      count_q  <= count_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    value_d  = value_q;
    power_d  = power_q;
    count_d  = count_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;
    finish_d = finish_q;

    case (state_q)
      IDLE: begin
        if (bus_io.start_i) begin
          base_d   = bus_io.base_i;
          value_d  = bus_io.value_i;
          power_d  = {{(pw-1){1'b0}}, 1'b1};
          count_d  = '0;
          finish_d = 1'b0;
          err_d    = 1'b0;
          exact_d  = 1'b0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        if (bad_operands) begin
          result_d = '0;
          err_d    = 1'b1;
          exact_d  = 1'b0;
          state_d  = DONE;
        end else if (step_ok) begin
          power_d = product[pw-1:0];
          count_d = count_q + one_c;
        end else begin
          result_d = count_q;
          exact_d  = (power_q == {{depth{1'b0}}, value_q});
          state_d  = DONE;
        end
      end
      DONE: begin
        // A held start must be released before another operation is accepted.
        finish_d = 1'b1;
        if (!bus_io.start_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_io.result_o = result_q;
  assign bus_io.exact_o  = exact_q;
  assign bus_io.err_o    = err_q;
  assign bus_io.finish_o = finish_q;

endmodule

// File: tb/tb_log_calc.sv
// Self-checking bench for log_calc: vector table, random model compare, corner sequences.
module tb_log_calc;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  log_calc_if #(.depth(3)) bus ();

  log_calc #(.depth(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int b;
    int v;
    int res;
    int ex;
    int er;
    int lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // floor(log_b(v)) from the definition: largest k with b**k <= v.
  function automatic void model(input int b, input int v,
                                output int r, output int ex, output int er, output int lat);
    if (b < 2 || v == 0) begin
      r = 0; ex = 0; er = 1; lat = 3;
    end else begin
      r = 0;
      while (b ** (r + 1) <= v) r++;
      ex  = (b ** r == v) ? 1 : 0;
      er  = 0;
      lat = r + 3;
    end
  endfunction

  // Raises start and counts edges (accepting edge = 1) until finish; start stays high.
  task automatic run_op(input int b, input int v, input bit scramble,
                        output int r, output int ex, output int er, output int lat);
    @(negedge clk);
    bus.base_i  = 3'(b);
    bus.value_i = 6'(v);
    bus.start_i = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1 && scramble) begin
        bus.base_i  = 3'($urandom_range(0, 7));
        bus.value_i = 6'($urandom_range(0, 63));
      end
      if (bus.finish_o) begin
        lat = n;
        break;
      end
    end
    r  = int'(bus.result_o);
    ex = int'(bus.exact_o);
    er = int'(bus.err_o);
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string tag, input int b, input int v, input bit scramble,
                               input int er_res, input int er_ex, input int er_er, input int er_lat);
    int r, ex, er, lat;
    run_op(b, v, scramble, r, ex, er, lat);
    check({tag, ".result"},  r,   er_res);
    check({tag, ".exact"},   ex,  er_ex);
    check({tag, ".err"},     er,  er_er);
    check({tag, ".latency"}, lat, er_lat);
    release_start();
  endtask

  initial begin
    int r, ex, er, lat;
    int mr, mex, mer, mlat;
    int b, v;

    total  = 0;
    passed = 0;

    vecs[0] = '{b:2, v:8,  res:3, ex:1, er:0, lat:6};
    vecs[1] = '{b:3, v:26, res:2, ex:0, er:0, lat:5};
    vecs[2] = '{b:7, v:63, res:2, ex:0, er:0, lat:5};
    vecs[3] = '{b:2, v:63, res:5, ex:0, er:0, lat:8};
    vecs[4] = '{b:2, v:1,  res:0, ex:1, er:0, lat:3};
    vecs[5] = '{b:1, v:9,  res:0, ex:0, er:1, lat:3};
    vecs[6] = '{b:5, v:0,  res:0, ex:0, er:1, lat:3};
    vecs[7] = '{b:7, v:49, res:2, ex:1, er:0, lat:5};
    vecs[8] = '{b:0, v:5,  res:0, ex:0, er:1, lat:3};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.base_i  = '0;
    bus.value_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", int'(bus.result_o), 0);
    check("reset.exact",  int'(bus.exact_o),  0);
    check("reset.err",    int'(bus.err_o),    0);
    check("reset.finish", int'(bus.finish_o), 0);
    check("reset.state",  int'(dut.state_q),  0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].v, 1'b0,
                    vecs[i].res, vecs[i].ex, vecs[i].er, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 7);
      v = $urandom_range(0, 63);
      model(b, v, mr, mex, mer, mlat);
      run_and_check($sformatf("rand%0d_b%0d_v%0d", i, b, v), b, v, 1'b1, mr, mex, mer, mlat);
    end

    // Held start: no second run even with new operands presented.
    run_op(3, 9, 1'b0, r, ex, er, lat);
    check("hold.first_result", r, 2);
    check("hold.first_exact",  ex, 1);
    @(negedge clk);
    bus.base_i  = 3'd2;
    bus.value_i = 6'd8;
    repeat (8) @(posedge clk);
    #1;
    check("hold.finish", int'(bus.finish_o), 1);
    check("hold.result", int'(bus.result_o), 2);
    check("hold.exact",  int'(bus.exact_o),  1);
    release_start();
    run_and_check("hold.rerun", 2, 8, 1'b0, 3, 1, 0, 6);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    bus.base_i  = 3'd2;
    bus.value_i = 6'd40;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("midrst.result", int'(bus.result_o), 0);
    check("midrst.exact",  int'(bus.exact_o),  0);
    check("midrst.err",    int'(bus.err_o),    0);
    check("midrst.finish", int'(bus.finish_o), 0);
    check("midrst.state",  int'(dut.state_q),  0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("midrst.rerun", 2, 40, 1'b0, 5, 0, 0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
